// File: rtl/io_port_responder_if.sv
// CPU I/O request/response channel, output-write channel and input-port load strobe.
interface io_port_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_device_id;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_device_id;
  logic [31:0] out_value;

  logic        in_load;
  logic [7:0]  in_load_id;
  logic [31:0] in_load_value;

  modport slave (
    input  req_valid, req_write, req_device_id, req_wdata,
    input  resp_ready, out_ready,
    input  in_load, in_load_id, in_load_value,
    output req_ready, resp_valid, resp_data, resp_err,
    output out_valid, out_device_id, out_value
  );

  modport master (
    output req_valid, req_write, req_device_id, req_wdata,
    output resp_ready, out_ready,
    output in_load, in_load_id, in_load_value,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  out_valid, out_device_id, out_value
  );
endinterface

// File: rtl/io_port_responder.sv
// I/O port responder: reads return input-port bank values through a one-deep
// response stage; writes are queued in an in-order FIFO toward the output sink.
module io_port_responder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NUM_IN     = 8
) (
  input  logic                clk,
  input  logic                reset,
  io_port_responder_if.slave  bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned ENT_W = 40;

  typedef enum logic {IDLE, RESP} state_e;

  state_e             state_q, state_d;
  logic [31:0]        bank_q [NUM_IN];
  logic [31:0]        bank_d [NUM_IN];
  logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic               resp_err_q, resp_err_d;

  logic full, req_fire, push, pop, rd_hit, load_hit;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign req_fire = bus.req_valid && (state_q == IDLE) && !full;
  assign push     = req_fire && bus.req_write;
  assign pop      = (count_q != '0) && bus.out_ready;
  assign rd_hit   = (32'(bus.req_device_id) < NUM_IN);
  assign load_hit = bus.in_load && (32'(bus.in_load_id) < NUM_IN);

  // Next-state: FSM, bank load, FIFO push/pop and read capture
  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    if (load_hit) bank_d[IDX_W'(bus.in_load_id)] = bus.in_load_value;

    if (push) begin
      fifo_d[wr_ptr_q] = {bus.req_device_id, bus.req_wdata};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (req_fire && !bus.req_write) begin
          // Bank is read from the registered copy so a same-cycle load returns the old value
          resp_data_d = rd_hit ? bank_q[IDX_W'(bus.req_device_id)] : 32'h0;
          resp_err_d  = !rd_hit;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_IN); i++) bank_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      bank_q      <= bank_d;
      fifo_q      <= fifo_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE) && !full;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.out_valid  = (count_q != '0);
  assign {bus.out_device_id, bus.out_value} = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboarded bench for io_port_responder: directed reads, writes, FIFO fill/wrap and reset.
module tb_io_port_responder;
  logic clk;
  logic reset;
  io_port_responder_if bus();

  io_port_responder #(.FIFO_DEPTH(4), .NUM_IN(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] resp_q[$];
  logic [63:0] out_q[$];
  logic [31:0] model_bank [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every completed handshake against the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (resp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL resp_unexpected: got %h expected none", bus.resp_data);
        end else
          check("resp", 64'({bus.resp_err, bus.resp_data}), resp_q.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL out_unexpected: got %h/%h expected none", bus.out_device_id, bus.out_value);
        end else
          check("out", 64'({bus.out_device_id, bus.out_value}), out_q.pop_front());
      end
    end
  end

  task automatic issue(input bit wr, input logic [7:0] id, input logic [31:0] d);
    bit ok = 1'b0;
    logic [63:0] exp = '0;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_device_id = id; bus.req_wdata = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        if (wr) exp = 64'({id, d});
        else if (id < 8) exp = 64'({1'b0, model_bank[id[2:0]]});
        else exp = 64'({1'b1, 32'h0});
      end
      tick();
    end
    bus.req_valid = 1'b0;
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL req_timeout: got req_ready=0 expected acceptance for id %0d", id);
    end else if (wr) out_q.push_back(exp);
    else resp_q.push_back(exp);
  endtask

  task automatic load(input logic [7:0] id, input logic [31:0] v);
    bus.in_load = 1'b1; bus.in_load_id = id; bus.in_load_value = v;
    tick();
    bus.in_load = 1'b0;
    if (id < 8) model_bank[id[2:0]] = v;
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60 && (out_q.size() != 0 || resp_q.size() != 0); n++) tick();
    check("drain_out_left", 64'(out_q.size()), 64'd0);
    check("drain_resp_left", 64'(resp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_device_id = '0; bus.req_wdata = '0;
    bus.resp_ready = 1'b0; bus.out_ready = 1'b0;
    bus.in_load = 1'b0; bus.in_load_id = '0; bus.in_load_value = '0;
    for (int i = 0; i < 8; i++) model_bank[i] = '0;
    tick(); tick();
    reset = 1'b0;

    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_id_val", 64'({bus.out_device_id, bus.out_value}), 64'd0);
    check("rst_resp_data_err", 64'({bus.resp_err, bus.resp_data}), 64'd0);

    // Read of a loaded port, response held until consumed
    load(8'd1, 32'hFFFF_FFFF);
    issue(1'b0, 8'd1, 32'h0);
    check("rd_latency", 64'(bus.resp_valid), 64'd1);
    tick(); tick();
    check("rd_hold_valid", 64'(bus.resp_valid), 64'd1);
    check("rd_hold_data", 64'({bus.resp_err, bus.resp_data}), 64'h0_FFFF_FFFF);
    check("rd_blocks_req", 64'(bus.req_ready), 64'd0);
    take_resp();
    check("rd_release", 64'(bus.resp_valid), 64'd0);
    check("rd_idle_ready", 64'(bus.req_ready), 64'd1);

    // Unmapped read
    issue(1'b0, 8'd200, 32'h0);
    check("unmapped_data_err", 64'({bus.resp_err, bus.resp_data}), 64'h1_0000_0000);
    take_resp();

    // Fill FIFO, fifth write stalls, then drain across pointer wrap
    check("no_bypass_pre", 64'(bus.out_valid), 64'd0);
    issue(1'b1, 8'd10, 32'd20);
    check("no_bypass_post", 64'(bus.out_valid), 64'd1);
    check("head_first", 64'({bus.out_device_id, bus.out_value}), 64'({8'd10, 32'd20}));
    for (int v = 21; v <= 23; v++) issue(1'b1, 8'd10, 32'(v));
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_device_id = 8'd10; bus.req_wdata = 32'd24;
    @(negedge clk);
    check("full_stall", 64'(bus.req_ready), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    issue(1'b1, 8'd10, 32'd24);
    drain();
    bus.out_ready = 1'b0;

    // Simultaneous push and pop keep occupancy
    issue(1'b1, 8'd3, 32'hA);
    bus.out_ready = 1'b1;
    issue(1'b1, 8'd4, 32'hB);
    bus.out_ready = 1'b0;
    check("pushpop_occupancy", 64'(bus.out_valid), 64'd1);
    check("pushpop_head", 64'({bus.out_device_id, bus.out_value}), 64'({8'd4, 32'hB}));
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;

    // Same-cycle load and read of id 6 returns old value
    bus.in_load = 1'b1; bus.in_load_id = 8'd6; bus.in_load_value = 32'h55AA_55AA;
    issue(1'b0, 8'd6, 32'h0);
    bus.in_load = 1'b0;
    model_bank[6] = 32'h55AA_55AA;
    take_resp();
    load(8'd9, 32'h1234_5678);
    issue(1'b0, 8'd6, 32'h0);
    take_resp();
    drain();

    // Reset mid-operation: two FIFO entries and a pending read, load ignored
    issue(1'b1, 8'd7, 32'h70);
    issue(1'b1, 8'd8, 32'h80);
    issue(1'b0, 8'd1, 32'h0);
    check("pre_reset_resp", 64'(bus.resp_valid), 64'd1);
    reset = 1'b1;
    bus.in_load = 1'b1; bus.in_load_id = 8'd2; bus.in_load_value = 32'h0BAD_0BAD;
    resp_q.delete();
    out_q.delete();
    tick();
    reset = 1'b0;
    bus.in_load = 1'b0;
    for (int i = 0; i < 8; i++) model_bank[i] = '0;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    issue(1'b0, 8'd1, 32'h0);
    check("post_rst_id1", 64'({bus.resp_err, bus.resp_data}), 64'd0);
    take_resp();
    issue(1'b0, 8'd2, 32'h0);
    check("post_rst_id2", 64'({bus.resp_err, bus.resp_data}), 64'd0);
    take_resp();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
